// File: rtl/mult32x32_fast_ctrl.sv
// Sequencer for a 16x16-bit datapath that builds a 32x32-bit product from up to
// four partial products. It picks the operand half-words, the partial-product
// shift and whether the product register is loaded or accumulated. With
// EARLY_TERM set, partial products whose operand upper half-word is zero are
// skipped.
//
// Handshake: start is a request sampled only in IDLE or in the done cycle; it is
// ignored while busy=1. done is a registered one-cycle pulse, high in the cycle
// after the last compute state, and the product register is final then. The
// requester holds the operands, and therefore a_msw_is_0/b_msw_is_0, stable from
// start until done.
module mult32x32_fast_ctrl #(
    parameter logic EARLY_TERM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       a_msw_is_0,
    input  logic       b_msw_is_0,
    output logic       busy,
    output logic       done,
    output logic       a_sel,
    output logic       b_sel,
    output logic [1:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_A0B0 = 3'd1;
    localparam logic [2:0] S_A0B1 = 3'd2;
    localparam logic [2:0] S_A1B0 = 3'd3;
    localparam logic [2:0] S_A1B1 = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       done_q;

    // Next-state selection: walk the partial products, skipping zero upper halves.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_A0B0;
            end
            S_A0B0: begin
                if (!EARLY_TERM || !b_msw_is_0)      state_nxt = S_A0B1;
                else if (!a_msw_is_0)                state_nxt = S_A1B0;
                else                                 state_nxt = S_IDLE;
            end
            S_A0B1: begin
                if (!EARLY_TERM || !a_msw_is_0)      state_nxt = S_A1B0;
                else                                 state_nxt = S_IDLE;
            end
            S_A1B0: begin
                if (!EARLY_TERM || !b_msw_is_0)      state_nxt = S_A1B1;
                else                                 state_nxt = S_IDLE;
            end
            S_A1B1: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and done pulse; done fires when a compute state hands back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state != S_IDLE) && (state_nxt == S_IDLE);
        end
    end

    // Moore decode of the datapath controls from the current state.
    always_comb begin
        busy      = 1'b0;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        shift_sel = 2'b00;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        case (state)
            S_A0B0: begin
                busy     = 1'b1;
                clr_prod = 1'b1;
            end
            S_A0B1: begin
                busy      = 1'b1;
                b_sel     = 1'b1;
                shift_sel = 2'b01;
                upd_prod  = 1'b1;
            end
            S_A1B0: begin
                busy      = 1'b1;
                a_sel     = 1'b1;
                shift_sel = 2'b01;
                upd_prod  = 1'b1;
            end
            S_A1B1: begin
                busy      = 1'b1;
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                shift_sel = 2'b10;
                upd_prod  = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign done      = done_q;
    assign state_dbg = state;

endmodule

// File: doc/mult32x32_fast_ctrl.md
MULT32X32_FAST_CTRL -- requirements
Module: mult32x32_fast_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter EARLY_TERM, default 1, SHALL skip partial products whose operand MSW is zero; 0 SHALL always run all four partial products.
REQ-003 Port clk input 1: clock; all state SHALL update on its rising edge.
REQ-004 Port reset input 1: synchronous active-high reset.
REQ-005 Port start input 1: request to begin a multiplication.
REQ-006 Port a_msw_is_0 input 1: MSW of operand A is zero, from the arithmetic unit.
REQ-007 Port b_msw_is_0 input 1: MSW of operand B is zero, from the arithmetic unit.
REQ-008 Port busy output 1: a multiplication is in progress.
REQ-009 Port done output 1: one-cycle pulse; the product is final.
REQ-010 Port a_sel output 1: A word select (0 = bits 15:0, 1 = bits 31:16).
REQ-011 Port b_sel output 1: B word select, same encoding as a_sel.
REQ-012 Port shift_sel output 2: partial-product shift (00 = 0, 01 = 16, 10 = 32 bits).
REQ-013 Port upd_prod output 1: accumulate the shifted partial product into the product register.
REQ-014 Port clr_prod output 1: load the product register with the shifted partial product, discarding the old value.

Function
REQ-015 The FSM SHALL have the states IDLE, A0B0, A0B1, A1B0 and A1B1; the state register SHALL be the only sequential element besides the done flop.
REQ-016 IDLE: busy=0, a_sel=0, b_sel=0, shift_sel=00, upd_prod=0, clr_prod=0; start=1 SHALL move the FSM to A0B0.
REQ-017 A0B0: a_sel=0, b_sel=0, shift_sel=00, clr_prod=1, upd_prod=0.
REQ-018 A0B1: a_sel=0, b_sel=1, shift_sel=01, upd_prod=1, clr_prod=0.
REQ-019 A1B0: a_sel=1, b_sel=0, shift_sel=01, upd_prod=1, clr_prod=0.
REQ-020 A1B1: a_sel=1, b_sel=1, shift_sel=10, upd_prod=1, clr_prod=0.
REQ-021 Outputs other than done SHALL be Moore (decoded from state only); busy SHALL be 1 in every non-IDLE state.
REQ-022 Transitions with EARLY_TERM=1:
- A0B0 -> A0B1 if !b_msw_is_0, else A1B0 if !a_msw_is_0, else IDLE.
- A0B1 -> A1B0 if !a_msw_is_0, else IDLE.
- A1B0 -> A1B1 if !b_msw_is_0, else IDLE.
- A1B1 -> IDLE.
REQ-023 With EARLY_TERM=0 the FSM SHALL ignore the MSW flags and always step A0B0 -> A0B1 -> A1B0 -> A1B1 -> IDLE.
REQ-024 done SHALL be registered and SHALL be 1 exactly in the cycle after the last compute state, with the FSM in IDLE; it is 0 at all other times.
REQ-025 Latency: start is sampled in cycle 0, N compute cycles follow (N in 1..4), and done is high in cycle N+1.
REQ-026 start while busy=1 SHALL be ignored, with no restart and no effect on the sequence.
REQ-027 start=1 in the done cycle SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-028 The requester SHALL hold a and b stable from start until done; the MSW flags are sampled in every compute state.
REQ-029 clr_prod and upd_prod SHALL never be 1 in the same cycle.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE and done=0 in any state, including mid-operation; all outputs then take their IDLE values.
REQ-031 reset SHALL take priority over start in the same cycle.
REQ-032 After reset is released, the first accepted start SHALL behave identically to a start from power-up.

Verification
REQ-033 a=0x0000FFFF, b=0x0000FFFF, start pulse -> states A0B0 only, done in cycle 2, product 0x00000000FFFE0001.
REQ-034 a=0x00010000, b=0x00020003 -> states A0B0, A0B1, A1B0, A1B1, done in cycle 5, product 0x0000000200030000.
REQ-035 a=0xFFFFFFFF, b=0x00000002 -> states A0B0, A1B0 (A0B1 skipped), done in cycle 3, product 0x00000001FFFFFFFE; a=0x00000003, b=0x00050000 -> states A0B0, A0B1, product 0x00000000000F0000.
REQ-036 start re-asserted in cycles 1-3 of the REQ-034 operation -> sequence and result unchanged; start held high through done -> second operation begins at A0B0 in the cycle after done.
REQ-037 reset asserted during A0B1 -> IDLE next cycle, busy=0, done=0, no done pulse; a new start then yields the correct product.
REQ-038 EARLY_TERM=0 with a=0x00000002, b=0x00000003 -> all four states visited, done in cycle 5, product 0x0000000000000006.
